mdu_iter: RTL and testbench

Iterative multiply/divide unit implementing the RV32M operation set for XLEN-wide operands. It sits beside the single-cycle ALU in the execute stage and handles MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. It uses a radix-2 shift-add multiplier and a restoring divider that share one accumulator. Operands arrive over a valid/ready request channel, and results leave over a valid/ready response channel, so the pipeline stalls on `in_ready`/`out_valid`.

---
 rtl/mdu_pkg.sv | 33 +++
 rtl/mdu_iter_if.sv | 24 ++
 rtl/mdu_iter.sv | 159 +++++++++++++++
 tb/tb_mdu_iter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared RV32M op codes, unit state encoding and operand signedness decode.
// Also imported by the ALU decode.
package mdu_pkg;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    // Returns {a_signed, b_signed} for a funct3 op
    function automatic logic [1:0] op_signed(input logic [2:0] op);
        logic [1:0] s;
        s = 2'b00;
        case (op)
            OP_MULH, OP_DIV, OP_REM: s = 2'b11;
            OP_MULHSU:               s = 2'b10;
            default:                 s = 2'b00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Request/response handshake bundle between execute stage and mdu_iter.
// The master side issues operands and consumes results.
interface mdu_iter_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiplier and
// restoring divider sharing one 2*XLEN accumulator.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    output logic       busy,
    mdu_iter_if.slave  bus
);

    localparam int CW = $clog2(XLEN);

    state_t            state;
    state_t            state_nx;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;
    logic [CW-1:0]     cnt;
    logic [2:0]        op_q;
    logic              q_neg;
    logic              r_neg;
    logic [XLEN-1:0]   res_q;

    logic            accept;
    logic [1:0]      sgn;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] special_res;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = res_q;
    assign busy          = (state != IDLE);

    assign accept = bus.in_valid & (state == IDLE) & ~flush;
    assign sgn    = op_signed(bus.op);
    assign a_neg  = sgn[1] & bus.a[XLEN-1];
    assign b_neg  = sgn[0] & bus.b[XLEN-1];
    assign a_mag  = a_neg ? -bus.a : bus.a;
    assign b_mag  = b_neg ? -bus.b : bus.b;

    assign div_zero = bus.op[2] & (bus.b == '0);
    assign div_ovf  = bus.op[2] & ~bus.op[0]
                    & (bus.a == {1'b1, {(XLEN-1){1'b0}}})
                    & (&bus.b);
    assign special  = div_zero | div_ovf;

    // op[1] selects the remainder for divide ops
    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = bus.op[1] ? bus.a : '1;
        end else if (div_ovf) begin
            special_res = bus.op[1] ? '0 : bus.a;
        end
    end

    // One multiply step: conditional add into high half, then shift right
    logic [XLEN:0]     add_sum;
    logic [XLEN:0]     hi_sel;
    logic [2*XLEN-1:0] mul_nx;

    assign add_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
    assign hi_sel  = acc[0] ? add_sum : {1'b0, acc[2*XLEN-1:XLEN]};
    assign mul_nx  = {hi_sel, acc[XLEN-1:1]};

    // One restoring divide step on {remainder, quotient}
    logic [XLEN:0]     div_t;
    logic [XLEN:0]     div_d;
    logic              div_ge;
    logic [2*XLEN-1:0] div_nx;

    assign div_t  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign div_d  = div_t - {1'b0, opnd};
    assign div_ge = ~div_d[XLEN];
    assign div_nx = {div_ge ? div_d[XLEN-1:0] : div_t[XLEN-1:0],
                     acc[XLEN-2:0], div_ge};

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fix_res;

    assign prod = q_neg ? -acc : acc;
    assign quo  = acc[XLEN-1:0];
    assign rem  = acc[2*XLEN-1:XLEN];

    always_comb begin
        fix_res = prod[XLEN-1:0];
        unique case (1'b1)
            op_q == OP_MUL:
                fix_res = prod[XLEN-1:0];
            !op_q[2] && op_q != OP_MUL:
                fix_res = prod[2*XLEN-1:XLEN];
            op_q[2] && !op_q[1]:
                fix_res = q_neg ? -quo : quo;
            op_q[2] && op_q[1]:
                fix_res = r_neg ? -rem : rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = special ? DONE : CALC;
            CALC: if (cnt == '0) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            opnd  <= '0;
            cnt   <= '0;
            op_q  <= OP_MUL;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            res_q <= '0;
        end else begin
            if (accept) begin
                op_q  <= bus.op;
                q_neg <= a_neg ^ b_neg;
                r_neg <= a_neg;
                opnd  <= b_mag;
                acc   <= {{XLEN{1'b0}}, a_mag};
                cnt   <= CW'(XLEN - 1);
                if (special) res_q <= special_res;
            end
            if (state == CALC && !flush) begin
                acc <= op_q[2] ? div_nx : mul_nx;
                cnt <= cnt - 1'b1;
            end
            if (state == FIX && !flush) begin
                res_q <= fix_res;
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: vector table, randomized ops against
// an arithmetic reference, and flush/reset/backpressure sequences.
module tb_mdu_iter;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic busy;

    mdu_iter_if #(.XLEN(XLEN)) bus ();

    mdu_iter #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_run = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        int ia;
        int ib;
        longint sa;
        longint sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0] p;
        logic [31:0] r;
        ia = a;
        ib = b;
        sa = ia;
        sb = ib;
        ua = {32'd0, a};
        ub = {32'd0, b};
        r = '0;
        case (op)
            3'd0: begin p = ua * ub; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = '1;
                else if (a == 32'h8000_0000 && b == '1) r = a;
                else r = ia / ib;
            end
            3'd5: r = (b == 0) ? '1 : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == '1) r = '0;
                else r = ia % ib;
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [2:0] op,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
        bit sp;
        sp = op[2] && (b == 0 || ((op == 3'd4 || op == 3'd6)
             && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        return sp ? 1 : 33;
    endfunction

    task automatic start(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        check("in_ready before request", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output logic [31:0] res, output int lat);
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.out_valid) break;
        end
        res = bus.result;
        if (!bus.out_valid) begin
            n_run++;
            n_fail++;
            $display("FAIL timeout: out_valid never rose");
        end
    endtask

    task automatic retire();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic run(input string name, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat);
        logic [31:0] r;
        int lat;
        start(op, a, b);
        wait_out(r, lat);
        check(name, r, exp);
        check({name, " latency"}, lat, exp_lat);
        retire();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] r;
        logic [31:0] held;
        int lat;
        int seen;

        vecs[0]  = '{3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 33};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'd5, 32'd100, 32'd7, 32'd14, 33};
        vecs[7]  = '{3'd7, 32'd100, 32'd7, 32'd2, 33};
        vecs[8]  = '{3'd5, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd6, 32'h1234, 32'd0, 32'h1234, 1};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1};
        vecs[12] = '{3'd4, 32'h55, 32'd0, 32'hFFFF_FFFF, 1};
        vecs[13] = '{3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33};
        vecs[14] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 33};
        vecs[15] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};

        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.op = '0;
        bus.a = '0;
        bus.b = '0;

        #2;
        check("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].exp, vecs[i].lat);
        end

        for (int i = 0; i < 150; i++) begin
            logic [2:0] op;
            logic [31:0] a;
            logic [31:0] b;
            op = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            run($sformatf("rand%0d op%0d %h %h", i, op, a, b), op, a, b,
                model(op, a, b), model_lat(op, a, b));
        end

        // flush asserted together with in_valid: nothing accepted
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = 3'd0;
        flush = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        flush = 1'b0;
        check("flush+valid busy", {31'd0, busy}, 32'd0);
        check("flush+valid in_ready", {31'd0, bus.in_ready}, 32'd1);

        // flush sampled at E11 of a DIV
        start(3'd4, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush calc in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("flush calc busy", {31'd0, busy}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 if (bus.out_valid) seen++;
        end
        check("flush calc no out_valid", seen, 0);
        run("mul after flush", 3'd0, 32'd3, 32'd5, 32'd15, 33);

        // flush while in FIX
        start(3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (32) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 if (bus.out_valid) seen++;
        end
        check("flush fix no out_valid", seen, 0);

        // flush in DONE drops the result even with out_ready
        start(3'd0, 32'd9, 32'd9);
        wait_out(r, lat);
        check("pre-flush done result", r, 32'd81);
        @(negedge clk);
        bus.out_ready = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        flush = 1'b0;
        check("flush done out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("flush done in_ready", {31'd0, bus.in_ready}, 32'd1);

        // backpressure then back-to-back request
        start(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        wait_out(r, lat);
        check("bp result", r, model(3'd0, 32'h1234_5678, 32'h9ABC_DEF0));
        check("bp latency", lat, 33);
        held = r;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp result stable", bus.result, held);
            check("bp in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.op = 3'd3;
        bus.a = 32'hCAFE_F00D;
        bus.b = 32'h0BAD_BEEF;
        @(posedge clk);
        #1;
        check("retire busy", {31'd0, busy}, 32'd0);
        check("retire in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        check("b2b accepted", {31'd0, busy}, 32'd1);
        wait_out(r, lat);
        check("b2b result", r, model(3'd3, 32'hCAFE_F00D, 32'h0BAD_BEEF));
        check("b2b latency", lat, 33);
        retire();

        // asynchronous reset mid-CALC
        start(3'd5, 32'hFFFF_0000, 32'd13);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async rst in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("async rst out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("async rst busy", {31'd0, busy}, 32'd0);
        check("async rst result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 if (bus.out_valid || busy) seen++;
        end
        check("after rst idle", seen, 0);
        run("div after rst", 3'd4, 32'hFFFF_FF9C, 32'd7,
            model(3'd4, 32'hFFFF_FF9C, 32'd7), 33);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
